// File: rtl/alu_cmd_sequencer.sv
// Sequences operands into an external combinational 4-bit ALU, from single commands or an exhaustive 2048-point sweep.
// Latency: response valid SETTLE edges after the operand-load edge; one operation per SETTLE+2 cycles in command mode.
// Backpressure: rsp_* held while rsp_ready is low; cmd_ready drops outside IDLE, so at most one operation is outstanding.
module alu_cmd_sequencer #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_a,
    input  logic [3:0]  cmd_b,
    input  logic [2:0]  cmd_sel,
    input  logic        sweep_start,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_sel,
    input  logic [3:0]  alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [3:0]  rsp_a,
    output logic [3:0]  rsp_b,
    output logic [2:0]  rsp_sel,
    output logic [3:0]  rsp_result,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        sweep_busy,
    output logic        sweep_done,
    output logic [10:0] rsp_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [10:0] IDX_LAST  = 11'h7FF;

    state_t      state, state_nxt;
    logic [3:0]  settle_cnt;
    logic [10:0] idx;
    logic [10:0] idx_inc;

    logic ld_cmd;
    logic ld_sweep;
    logic ld_next;
    logic capture;
    logic consume;
    logic sweep_end;

    assign idx_inc = idx + 11'd1;

    // Reset gates cmd_ready so nothing is accepted while the block is held in reset.
    assign cmd_ready = rst_n && (state == IDLE) && !sweep_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_cmd    = 1'b0;
        ld_sweep  = 1'b0;
        ld_next   = 1'b0;
        capture   = 1'b0;
        consume   = 1'b0;
        sweep_end = 1'b0;
        case (state)
            IDLE: begin
                if (sweep_start) begin
                    ld_sweep  = 1'b1;
                    state_nxt = WAIT;
                end else if (cmd_valid) begin
                    ld_cmd    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (settle_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    consume = 1'b1;
                    if (sweep_busy) begin
                        if (idx == IDX_LAST) begin
                            sweep_end = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ld_next   = 1'b1;
                            state_nxt = WAIT;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand drive, settle timer and sweep index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_sel    <= 3'd0;
            settle_cnt <= 4'd0;
            idx        <= 11'd0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= sweep_end;
            if (ld_cmd || ld_sweep || ld_next) begin
                settle_cnt <= SETTLE_M1;
            end else if (state == WAIT && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (ld_cmd) begin
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
                alu_sel <= cmd_sel;
            end else if (ld_sweep) begin
                idx        <= 11'd0;
                alu_a      <= 4'd0;
                alu_b      <= 4'd0;
                alu_sel    <= 3'd0;
                sweep_busy <= 1'b1;
            end else if (ld_next) begin
                idx     <= idx_inc;
                alu_a   <= idx_inc[10:7];
                alu_b   <= idx_inc[6:3];
                alu_sel <= idx_inc[2:0];
            end
            if (sweep_end) begin
                sweep_busy <= 1'b0;
            end
        end
    end

    // Response holding register and consumed-response counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_a      <= 4'd0;
            rsp_b      <= 4'd0;
            rsp_sel    <= 3'd0;
            rsp_result <= 4'd0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_count  <= 11'd0;
        end else begin
            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_a      <= alu_a;
                rsp_b      <= alu_b;
                rsp_sel    <= alu_sel;
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
                rsp_zero   <= alu_zero;
            end else if (consume) begin
                rsp_valid <= 1'b0;
            end
            if (consume) begin
                rsp_count <= rsp_count + 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: SETTLE=1 instance for commands/sweeps/reset, SETTLE=4 instance for latency.
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // SETTLE=1 instance
    logic        cmd_valid, cmd_ready, sweep_start, rsp_valid, rsp_ready;
    logic [3:0]  cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_a, rsp_b, rsp_result;
    logic [2:0]  cmd_sel, alu_sel, rsp_sel;
    logic        alu_carry, alu_zero, rsp_carry, rsp_zero, sweep_busy, sweep_done;
    logic [10:0] rsp_count;
    logic [4:0]  sum1;

    assign sum1       = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_result = sum1[3:0];
    assign alu_carry  = sum1[4];
    assign alu_zero   = (sum1[3:0] == 4'd0);

    alu_cmd_sequencer #(.SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .sweep_start(sweep_start),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_sel(rsp_sel),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done), .rsp_count(rsp_count)
    );

    // SETTLE=4 instance
    logic        c4_cmd_valid, c4_cmd_ready, c4_sweep_start, c4_rsp_valid, c4_rsp_ready;
    logic [3:0]  c4_cmd_a, c4_cmd_b, c4_alu_a, c4_alu_b, c4_alu_result, c4_rsp_a, c4_rsp_b, c4_rsp_result;
    logic [2:0]  c4_cmd_sel, c4_alu_sel, c4_rsp_sel;
    logic        c4_alu_carry, c4_alu_zero, c4_rsp_carry, c4_rsp_zero, c4_sweep_busy, c4_sweep_done;
    logic [10:0] c4_rsp_count;
    logic [4:0]  sum4;

    assign sum4          = {1'b0, c4_alu_a} + {1'b0, c4_alu_b};
    assign c4_alu_result = sum4[3:0];
    assign c4_alu_carry  = sum4[4];
    assign c4_alu_zero   = (sum4[3:0] == 4'd0);

    alu_cmd_sequencer #(.SETTLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(c4_cmd_valid), .cmd_ready(c4_cmd_ready),
        .cmd_a(c4_cmd_a), .cmd_b(c4_cmd_b), .cmd_sel(c4_cmd_sel),
        .sweep_start(c4_sweep_start),
        .alu_a(c4_alu_a), .alu_b(c4_alu_b), .alu_sel(c4_alu_sel),
        .alu_result(c4_alu_result), .alu_carry(c4_alu_carry), .alu_zero(c4_alu_zero),
        .rsp_valid(c4_rsp_valid), .rsp_ready(c4_rsp_ready),
        .rsp_a(c4_rsp_a), .rsp_b(c4_rsp_b), .rsp_sel(c4_rsp_sel),
        .rsp_result(c4_rsp_result), .rsp_carry(c4_rsp_carry), .rsp_zero(c4_rsp_zero),
        .sweep_busy(c4_sweep_busy), .sweep_done(c4_sweep_done), .rsp_count(c4_rsp_count)
    );

    int           n_chk = 0;
    int           n_err = 0;
    int           exp_count = 0;
    logic [16:0]  q[$];
    logic [16:0]  exp_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {a, b, sel, result, carry, zero} for the a+b ALU stub.
    function automatic logic [16:0] model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        logic [4:0] sm;
        sm = {1'b0, a} + {1'b0, b};
        return {a, b, s, sm[3:0], sm[4], (sm[3:0] == 4'd0)};
    endfunction

    function automatic logic [16:0] sweep_model(input int i);
        logic [10:0] v;
        v = 11'(i);
        return model(v[10:7], v[6:3], v[2:0]);
    endfunction

    task automatic pop_chk();
        chk("sb_nonempty", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
            exp_last = q.pop_front();
            chk("rsp", {rsp_a, rsp_b, rsp_sel, rsp_result, rsp_carry, rsp_zero}, exp_last);
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_ctl"}, {cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, sweep_busy, sweep_done}, 0);
        chk({tag, "_rsp"}, {rsp_a, rsp_b, rsp_sel, rsp_result, rsp_carry, rsp_zero, rsp_count}, 0);
        chk({tag, "_s4"}, {c4_cmd_ready, c4_rsp_valid, c4_alu_a, c4_alu_b, c4_rsp_count}, 0);
    endtask

    task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s, input int hold);
        int n;
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
        #1;
        chk("cmd_ready", cmd_ready, 1);
        q.push_back(model(a, b, s));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("alu_ops", {alu_a, alu_b, alu_sel}, {a, b, s});
        chk("wait_ready", cmd_ready, 0);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 1);
        pop_chk();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rsp", {rsp_valid, rsp_a, rsp_b, rsp_sel, rsp_result, rsp_carry, rsp_zero}, {1'b1, exp_last});
            chk("hold_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_count = (exp_count + 1) % 2048;
        chk("rsp_valid_clr", rsp_valid, 0);
        chk("rsp_count", rsp_count, exp_count);
        chk("idle_ready", cmd_ready, 1);
    endtask

    initial begin
        int n, cyc, n_rsp, n_done, ready_bad, c0;
        bit acc, found;

        rst_n = 1'b0;
        cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_sel = 0; sweep_start = 0; rsp_ready = 0;
        c4_cmd_valid = 0; c4_cmd_a = 0; c4_cmd_b = 0; c4_cmd_sel = 0; c4_sweep_start = 0; c4_rsp_ready = 0;
        #2;
        reset_chk("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic command, then a held response that wraps to zero with carry.
        run_cmd(4'd3, 4'd5, 3'd0, 0);
        run_cmd(4'd9, 4'd7, 3'd2, 5);
        for (int k = 0; k < 6; k++)
            run_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), k % 3);

        // SETTLE=4 latency and operand stability.
        @(negedge clk);
        c4_cmd_a = 4'd12; c4_cmd_b = 4'd7; c4_cmd_sel = 3'd5; c4_cmd_valid = 1'b1;
        #1;
        chk("s4_ready", c4_cmd_ready, 1);
        @(negedge clk);
        c4_cmd_valid = 1'b0;
        n = 0;
        while (!c4_rsp_valid && n < 40) begin
            chk("s4_alu_stable", {c4_alu_a, c4_alu_b, c4_alu_sel}, {4'd12, 4'd7, 3'd5});
            @(negedge clk);
            n++;
        end
        chk("s4_latency", n, 4);
        chk("s4_rsp", {c4_rsp_a, c4_rsp_b, c4_rsp_sel, c4_rsp_result, c4_rsp_carry, c4_rsp_zero},
            model(4'd12, 4'd7, 3'd5));
        c4_rsp_ready = 1'b1;
        @(negedge clk);
        c4_rsp_ready = 1'b0;
        chk("s4_count", c4_rsp_count, 1);
        chk("s4_valid_clr", c4_rsp_valid, 0);

        // Full sweep with a competing command offered in the start cycle.
        @(negedge clk);
        c0 = exp_count;
        sweep_start = 1'b1; cmd_valid = 1'b1; cmd_a = 4'd1; cmd_b = 4'd1; cmd_sel = 3'd0;
        #1;
        chk("start_ready", cmd_ready, 0);
        for (int i = 0; i < 2048; i++) q.push_back(sweep_model(i));
        rsp_ready = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        chk("sweep_busy", sweep_busy, 1);
        chk("sweep_first_ops", {alu_a, alu_b, alu_sel}, 0);
        n_rsp = 0; n_done = 0; ready_bad = 0; acc = 0; cyc = 0;
        while (!(acc && n_rsp == 2049) && cyc < 6000) begin
            if (rsp_valid) begin
                pop_chk();
                n_rsp++;
            end
            if (sweep_done) begin
                n_done++;
                chk("count_wrap", rsp_count, 32'(c0));
            end
            if (sweep_busy && cmd_ready) ready_bad++;
            if (cmd_valid && cmd_ready) begin
                chk("cmd_after_done", sweep_done, 1);
                q.push_back(model(4'd1, 4'd1, 3'd0));
                acc = 1;
            end
            @(negedge clk);
            cyc++;
            if (acc) cmd_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        exp_count = (c0 + 2049) % 2048;
        chk("sweep_responses", n_rsp, 2049);
        chk("sweep_done_pulses", n_done, 1);
        chk("ready_while_busy", ready_bad, 0);
        chk("cmd_accepted", 32'(acc), 1);
        chk("count_after", rsp_count, 32'(exp_count));
        chk("busy_clear", sweep_busy, 0);

        // Reset in RESP at idx 100 aborts the sweep.
        @(negedge clk);
        sweep_start = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2048; i++) q.push_back(sweep_model(i));
        @(negedge clk);
        sweep_start = 1'b0;
        found = 0; cyc = 0;
        while (!found && cyc < 1000) begin
            if (rsp_valid) begin
                pop_chk();
                if ({rsp_a, rsp_b, rsp_sel} == 11'd100) found = 1;
            end
            if (!found) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("found_idx100", 32'(found), 1);
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        #1;
        reset_chk("midreset");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("no_done_in_reset", {sweep_busy, sweep_done}, 0);
        end
        q.delete();
        exp_count = 0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", cmd_ready, 1);
        chk("post_reset_done", sweep_done, 0);
        sweep_start = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) q.push_back(sweep_model(i));
        @(negedge clk);
        sweep_start = 1'b0;
        chk("restart_ops", {alu_a, alu_b, alu_sel}, 0);
        n_rsp = 0; cyc = 0;
        while (n_rsp < 3 && cyc < 40) begin
            if (rsp_valid) begin
                pop_chk();
                n_rsp++;
            end
            @(negedge clk);
            cyc++;
        end
        rsp_ready = 1'b0;
        chk("restart_responses", n_rsp, 3);
        chk("restart_count", rsp_count, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter: SETTLE, default 1, range 1..15; number of clock edges between driving ALU operands and sampling ALU outputs.
REQ-002 Clocking SHALL be one clock, clk; reset SHALL be rst_n, asynchronous, active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when high with cmd_valid at a rising edge.
REQ-007 cmd_a, cmd_b  input  4 each  command operands.
REQ-008 cmd_sel  input  3  command operation select.
REQ-009 sweep_start  input  1  single-cycle request for an exhaustive sweep.
REQ-010 alu_a, alu_b  output  4 each  operands driven to the external 4-bit ALU.
REQ-011 alu_sel  output  3  select driven to the ALU.
REQ-012 alu_result  input  4; alu_carry, alu_zero  input  1 each  ALU outputs.
REQ-013 rsp_valid  output  1  response held.
REQ-014 rsp_ready  input  1  response consumed when high with rsp_valid at a rising edge.
REQ-015 rsp_a, rsp_b  output  4 each; rsp_sel  output  3  echo of the operands that produced the response.
REQ-016 rsp_result  output  4; rsp_carry, rsp_zero  output  1 each  sampled ALU outputs.
REQ-017 sweep_busy  output  1  sweep in progress.
REQ-018 sweep_done  output  1  one-cycle pulse at sweep completion.
REQ-019 rsp_count  output  11  count of consumed responses, wraps modulo 2048.

Function
REQ-020 The FSM SHALL have the states IDLE, WAIT and RESP, with at most one operation outstanding.
REQ-021 cmd_ready SHALL equal (state==IDLE) && !sweep_start, combinationally.
REQ-022 In IDLE, a rising edge with sweep_start high SHALL clear index idx to 0, drive {alu_a,alu_b,alu_sel} = idx[10:0], set sweep_busy and enter WAIT; sweep_start SHALL have priority over cmd_valid.
REQ-023 In IDLE, a cmd_valid&&cmd_ready edge SHALL load alu_a/alu_b/alu_sel from cmd_a/cmd_b/cmd_sel and enter WAIT.
REQ-024 WAIT SHALL last exactly SETTLE edges counted from the operand-load edge; on the SETTLE-th edge the block SHALL capture alu_result/carry/zero and alu_a/b/sel into rsp_*, set rsp_valid and enter RESP.
REQ-025 alu_* SHALL remain stable from the load edge until the next load.
REQ-026 In RESP, rsp_* and rsp_valid SHALL hold stable while rsp_ready is low.
REQ-027 On a rsp_valid&&rsp_ready edge, rsp_valid SHALL clear and rsp_count SHALL increment, wrapping 2047->0.
REQ-028 On that same edge in sweep mode with idx<2047: idx SHALL increment, the next operands SHALL load, and the FSM SHALL enter WAIT (no idle gap).
REQ-029 On that same edge in sweep mode with idx==2047: sweep_done SHALL pulse for one cycle, sweep_busy SHALL clear and the FSM SHALL enter IDLE.
REQ-030 On that same edge in command mode, the FSM SHALL enter IDLE.
REQ-031 sweep_start outside IDLE SHALL be ignored.
REQ-032 cmd_valid SHALL be ignored while sweep_busy is set.
REQ-033 Minimum command-mode throughput SHALL be one operation per SETTLE+2 cycles.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and the following values: alu_a/b/sel=0, all rsp_*=0, rsp_valid=0, rsp_count=0, idx=0, sweep_busy=0, sweep_done=0.
REQ-035 Reset mid-operation SHALL discard the in-flight operation and abort any sweep without a sweep_done pulse.
REQ-036 cmd_ready SHALL be 0 while rst_n is low and SHALL follow REQ-021 from the first edge after release.

Verification (bench ALU stub: result=(a+b)[3:0], carry=(a+b)[4], zero=(result==0))
REQ-037 SETTLE=1, cmd a=3,b=5,sel=0 -> alu_a=3,alu_b=5 after the accept edge; rsp_valid on the next edge with rsp_result=8, carry=0, zero=0, rsp_a=3, rsp_b=5; rsp_count=1 after consumption.
REQ-038 cmd a=9,b=7 with rsp_ready low for 5 cycles -> rsp_result=0, carry=1, zero=1 held constant; cmd_ready=0 throughout; IDLE on the 6th-cycle handshake.
REQ-039 SETTLE=1, sweep_start, rsp_ready=1 -> 2048 responses, first {0,0,000}, last {F,F,111} with result=E, carry=1; exactly one sweep_done pulse; rsp_count wraps back to its start value.
REQ-040 sweep_start and cmd_valid (a=1,b=1) in the same IDLE cycle -> cmd_ready=0, sweep runs; the command is accepted on the first IDLE cycle after sweep_done.
REQ-041 rst_n low while idx=100 in RESP -> all outputs at reset values immediately, sweep_busy=0, no sweep_done; a new sweep starts at idx 0.
REQ-042 SETTLE=4, single command -> rsp_valid asserted exactly 4 edges after the accept edge; alu_* stable throughout.
